// File: rtl/vid_dma_pkg.sv
// rtl/vid_dma_pkg.sv - shared types, widths and pixel packing for the video capture DMA
package vid_dma_pkg;

  localparam int CTRL_LEN_W = 8;
  localparam int ADDR_W     = 32;
  localparam logic [3:0] STRB_ALL = 4'hF;

  localparam int PIX_FMT_RGBX = 0;
  localparam int PIX_FMT_XBGR = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE
  } state_t;

  // Incoming pixels arrive as {R, B, G}; memory wants R,G,B order in either endianness.
  function automatic logic [31:0] pack_pixel(input logic [23:0] rgb, input int fmt);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = rgb[23:16];
    b = rgb[15:8];
    g = rgb[7:0];
    return (fmt == PIX_FMT_XBGR) ? {8'hFF, b, g, r} : {r, g, b, 8'hFF};
  endfunction

endpackage

// File: rtl/vid_capture_dma_if.sv
// rtl/vid_capture_dma_if.sv - DRAM write port: data beats, burst commands, command FIFO full
interface vid_capture_dma_if;
  import vid_dma_pkg::*;

  logic [35:0]                  data_in;
  logic                         data_we;
  logic [CTRL_LEN_W+ADDR_W-1:0] ctrl_in;
  logic                         ctrl_we;
  logic                         ctrl_full;

  modport master (output data_in, data_we, ctrl_in, ctrl_we, input ctrl_full);
  modport slave  (input data_in, data_we, ctrl_in, ctrl_we, output ctrl_full);
endinterface

// File: rtl/burst_gen.sv
// rtl/burst_gen.sv - counts registered beats and emits one {len, addr} command per burst
module burst_gen
  import vid_dma_pkg::*;
#(
  parameter int BURST_LEN = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         beat_valid,
  input  logic                         beat_last,
  input  logic [ADDR_W-1:0]            beat_addr,
  input  logic                         flush,
  output logic [CTRL_LEN_W+ADDR_W-1:0] ctrl_in,
  output logic                         ctrl_we
);

  localparam logic [CTRL_LEN_W-1:0] LEN_MAX = CTRL_LEN_W'(BURST_LEN);

  logic [CTRL_LEN_W-1:0] burst_cnt;
  logic [CTRL_LEN_W-1:0] cnt_inc;
  logic [ADDR_W-1:0]     burst_addr;
  logic [ADDR_W-1:0]     cmd_addr;
  logic                  emit;

  // Beat and terminating event may land on the same edge; fold them into one command.
  always_comb begin
    cnt_inc  = burst_cnt + {{(CTRL_LEN_W-1){1'b0}}, beat_valid};
    cmd_addr = (burst_cnt == '0) ? beat_addr : burst_addr;
    emit     = (cnt_inc != '0) &&
               ((cnt_inc == LEN_MAX) || (beat_valid && beat_last) || flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt  <= '0;
      burst_addr <= '0;
      ctrl_in    <= '0;
      ctrl_we    <= 1'b0;
    end else begin
      ctrl_we <= emit;
      if (emit) ctrl_in <= {cnt_inc, cmd_addr};
      burst_cnt <= emit ? '0 : cnt_inc;
      if (beat_valid && burst_cnt == '0) burst_addr <= beat_addr;
    end
  end

endmodule

// File: rtl/vid_capture_dma.sv
// rtl/vid_capture_dma.sv - DE-qualified RGB capture into ping-pong DRAM frame buffers
module vid_capture_dma
  import vid_dma_pkg::*;
#(
  parameter int          WIDTH     = 1600,
  parameter int          HEIGHT    = 1200,
  parameter int          BURST_LEN = 64,
  parameter logic [31:0] BASE0     = 32'h0000_0000,
  parameter logic [31:0] BASE1     = 32'h0080_0000,
  parameter int          PIX_FMT   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vsync_n,
  input  logic                      hsync,
  input  logic                      de,
  input  logic [23:0]               rgb_data,
  input  logic                      cap_start,
  input  logic                      cap_cont,
  input  logic                      cap_stop,
  vid_capture_dma_if.master         dram,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      frame_buf,
  output logic                      overflow
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0]     X_END      = XW'(WIDTH);
  localparam logic [XW-1:0]     X_LAST     = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_END      = YW'(HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WIDTH * 4);

  state_t            state;
  logic              vs_prev, de_prev, buf_sel, cont, stop_seen;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [ADDR_W-1:0] line_addr;
  logic              beat_valid, beat_last;
  logic [ADDR_W-1:0] beat_addr;
  logic [35:0]       data_q;
  logic              vs_rise, de_fall, frame_end, cap_de;
  logic [ADDR_W-1:0] pix_addr;

  assign vs_rise   = ~vsync_n & ~vs_prev;
  assign de_fall   = de_prev & ~de;
  assign frame_end = (state == ST_CAPTURE) && vs_rise;
  assign cap_de    = (state == ST_CAPTURE) && de && (x_cnt < X_END) && (y_cnt < Y_END);
  assign pix_addr  = line_addr + (ADDR_W'(x_cnt) << 2);
  assign busy      = (state != ST_IDLE);
  assign dram.data_we = beat_valid;
  assign dram.data_in = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
      x_cnt   <= '0;
    end else begin
      vs_prev <= ~vsync_n;
      de_prev <= de;
      if (hsync) x_cnt <= '0;
      else if (de && x_cnt != X_END) x_cnt <= x_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      buf_sel    <= 1'b0;
      cont       <= 1'b0;
      stop_seen  <= 1'b0;
      y_cnt      <= '0;
      line_addr  <= '0;
      frame_done <= 1'b0;
      frame_buf  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (dram.ctrl_we && dram.ctrl_full) overflow <= 1'b1;
      case (state)
        ST_IDLE: if (cap_start) begin
          state     <= ST_ARMED;
          cont      <= cap_cont;
          stop_seen <= 1'b0;
          overflow  <= 1'b0;
        end
        ST_ARMED: if (cap_stop) begin
          state <= ST_IDLE;
        end else if (vs_rise) begin
          state     <= ST_CAPTURE;
          line_addr <= buf_sel ? BASE1 : BASE0;
          y_cnt     <= '0;
        end
        ST_CAPTURE: begin
          if (cap_stop) stop_seen <= 1'b1;
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_buf  <= buf_sel;
            buf_sel    <= ~buf_sel;
            line_addr  <= buf_sel ? BASE0 : BASE1;
            y_cnt      <= '0;
            if (!cont || stop_seen || cap_stop) state <= ST_IDLE;
          end else if (de_fall) begin
            line_addr <= line_addr + LINE_BYTES;
            if (y_cnt != Y_END) y_cnt <= y_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Beat stage: everything downstream (data port, burst counter) sees pixels one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_valid <= 1'b0;
      beat_last  <= 1'b0;
      beat_addr  <= '0;
      data_q     <= '0;
    end else begin
      beat_valid <= cap_de;
      beat_last  <= cap_de && (x_cnt == X_LAST);
      if (cap_de) begin
        beat_addr <= pix_addr;
        data_q    <= {STRB_ALL, pack_pixel(rgb_data, PIX_FMT)};
      end
    end
  end

  burst_gen #(.BURST_LEN(BURST_LEN)) u_burst_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .beat_addr  (beat_addr),
    .flush      (de_fall | frame_end),
    .ctrl_in    (dram.ctrl_in),
    .ctrl_we    (dram.ctrl_we)
  );

endmodule
